// File: rtl/gate_pkg.sv
// gate_pkg: gate mode encodings, sweeper FSM states and the shared gate reference function
package gate_pkg;
  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_NAND = 3'd2;
  localparam logic [2:0] MODE_NOR  = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;
  localparam logic [2:0] MODE_BUF  = 3'd6;
  localparam logic [2:0] MODE_INV  = 3'd7;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
  function automatic logic gate_eval(input logic [15:0] v, input logic [2:0] mode, input int n);
    logic [15:0] m;
    logic a, o, x;
    m = 16'hffff >> (16 - n);
    a = &(v | ~m);
    o = |(v & m);
    x = ^(v & m);
    return mode == MODE_AND  ? a :
           mode == MODE_OR   ? o :
           mode == MODE_NAND ? ~a :
           mode == MODE_NOR  ? ~o :
           mode == MODE_XOR  ? x :
           mode == MODE_XNOR ? ~x :
           mode == MODE_BUF  ? v[0] :
           mode == MODE_INV  ? ~v[0] : 1'b0;
  endfunction
endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational reference output of an N_IN-input gate selected by mode
module gate_ref_model
  import gate_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic [N_IN-1:0] vec,
  input  logic [2:0]      mode,
  output logic            ref_out
);
  assign ref_out = gate_eval(16'(vec), mode, N_IN);
endmodule

// File: rtl/gate_equiv_sweeper.sv
// gate_equiv_sweeper: exhaustive input sweep of an external gate, checked against a reference
module gate_equiv_sweeper
  import gate_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      mode,
  input  logic            dut_out,
  output logic [N_IN-1:0] vec,
  output logic            ref_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_valid
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] vec_q, vec_d, fev_q, fev_d;
  logic [N_IN:0]   err_q, err_d;
  logic [2:0]      mode_q, mode_d;
  logic            fvalid_q, fvalid_d, done_q, done_d, pass_q, pass_d;
  logic            mis;
  gate_ref_model #(.N_IN(N_IN)) u_ref (.vec(vec_q), .mode(mode_q), .ref_out(ref_out));
  assign mis = dut_out != ref_out;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    err_d    = err_q;
    fev_d    = fev_q;
    fvalid_d = fvalid_q;
    done_d   = done_q;
    pass_d   = pass_q;
    mode_d   = mode_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) begin
        mode_d   = mode;
        vec_d    = '0;
        err_d    = '0;
        fev_d    = '0;
        fvalid_d = 1'b0;
        done_d   = 1'b0;
        pass_d   = 1'b0;
        cnt_d    = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: if (cnt_q == CW'(SETTLE - 1)) state_d = ST_SAMPLE;
                 else cnt_d = cnt_q + 1'b1;
      ST_SAMPLE: begin
        if (mis) begin
          err_d = err_q + 1'b1;
          if (!fvalid_q) begin
            fev_d    = vec_q;
            fvalid_d = 1'b1;
          end
        end
        if (&vec_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = err_d == '0;
        end else begin
          vec_d   = vec_q + 1'b1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      vec_q    <= '0;
      err_q    <= '0;
      fev_q    <= '0;
      fvalid_q <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      mode_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      fev_q    <= fev_d;
      fvalid_q <= fvalid_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      mode_q   <= mode_d;
    end
  end
  assign vec             = vec_q;
  assign busy            = state_q == ST_SETTLE || state_q == ST_SAMPLE;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_vec   = fev_q;
  assign first_err_valid = fvalid_q;
endmodule

// File: tb/tb_gate_equiv_sweeper.sv
// tb_gate_equiv_sweeper: scoreboard bench sweeping good and faulty gates through the sweeper
module tb_gate_equiv_sweeper;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       dut_out;
  logic [2:0] vec;
  logic       ref_out, busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_err_vec;
  logic       first_err_valid;
  int         checks = 0;
  int         failures = 0;
  int         dut_mode = 0;
  logic       dut_stuck = 1'b0;
  typedef struct {
    logic [3:0] err;
    logic [2:0] fev;
    logic       fvalid;
    logic       pass;
  } exp_t;
  exp_t sb[$];
  localparam int LAT = 1 + 8 * 2;
  function automatic logic exp_ref(input int m, input logic [2:0] v);
    case (m)
      0: return v == 3'b111;
      1: return v != 3'b000;
      2: return v != 3'b111;
      3: return v == 3'b000;
      4: return v[0] ^ v[1] ^ v[2];
      5: return !(v[0] ^ v[1] ^ v[2]);
      6: return v[0];
      default: return !v[0];
    endcase
  endfunction
  assign dut_out = dut_stuck ? 1'b0 : exp_ref(dut_mode, vec);
  gate_equiv_sweeper #(.N_IN(3), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .dut_out(dut_out), .vec(vec),
    .ref_out(ref_out), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
  );
  always #5 clk = ~clk;
  task automatic check_idle(input string tag);
    checks++;
    if ({vec, ref_out, busy, done, pass, err_count, first_err_vec, first_err_valid} !== 15'd0) begin
      failures++;
      $display("FAIL %s outputs: vec=%b ref=%b busy=%b done=%b pass=%b err=%0d fev=%b fv=%b required all 0",
               tag, vec, ref_out, busy, done, pass, err_count, first_err_vec, first_err_valid);
    end
  endtask
  task automatic run_sweep(input int m, input int dm, input logic stuck, input bit poke, input string tag);
    exp_t e;
    exp_t got;
    int cyc;
    bit pulsed;
    logic r, d;
    e = '{err: 4'd0, fev: 3'd0, fvalid: 1'b0, pass: 1'b0};
    for (int v = 0; v < 8; v++) begin
      r = exp_ref(m, 3'(v));
      d = stuck ? 1'b0 : exp_ref(dm, 3'(v));
      if (r != d) begin
        if (!e.fvalid) begin
          e.fev = 3'(v);
          e.fvalid = 1'b1;
        end
        e.err++;
      end
    end
    e.pass = e.err == 0;
    sb.push_back(e);
    @(negedge clk);
    mode = 3'(m);
    dut_mode = dm;
    dut_stuck = stuck;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || err_count !== 4'd0 || first_err_valid !== 1'b0 || vec !== 3'd0) begin
      failures++;
      $display("FAIL %s first_cycle: busy=%b done=%b err=%0d fv=%b vec=%b required busy=1 rest 0",
               tag, busy, done, err_count, first_err_valid, vec);
    end
    pulsed = 0;
    while (!done && cyc < 100) begin
      if (busy) begin
        checks++;
        if (ref_out !== exp_ref(m, vec)) begin
          failures++;
          $display("FAIL %s ref_out vec=%b: got %b required %b", tag, vec, ref_out, exp_ref(m, vec));
        end
      end
      if (poke && vec == 3'b010 && !pulsed) begin
        start = 1'b1;
        mode = 3'(m) ^ 3'd5;
        pulsed = 1;
      end else start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    got = '{err: err_count, fev: first_err_vec, fvalid: first_err_valid, pass: pass};
    e = sb.pop_front();
    checks++;
    if (cyc !== LAT || done !== 1'b1) begin
      failures++;
      $display("FAIL %s latency: done=%b after %0d cycles required 1 after %0d", tag, done, cyc, LAT);
    end
    checks++;
    if (got.err !== e.err || got.pass !== e.pass) begin
      failures++;
      $display("FAIL %s result: err=%0d pass=%b required err=%0d pass=%b", tag, got.err, got.pass, e.err, e.pass);
    end
    checks++;
    if (got.fvalid !== e.fvalid || (e.fvalid && got.fev !== e.fev)) begin
      failures++;
      $display("FAIL %s first_err: valid=%b vec=%b required valid=%b vec=%b", tag, got.fvalid, got.fev, e.fvalid, e.fev);
    end
    @(posedge clk);
    #1;
    checks++;
    if (vec !== 3'b111 || busy !== 1'b0 || done !== 1'b1 || pass !== e.pass) begin
      failures++;
      $display("FAIL %s hold_done: vec=%b busy=%b done=%b pass=%b required 111 0 1 %b", tag, vec, busy, done, pass, e.pass);
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    mode = 3'd3;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check_idle("idle_after_reset");
  endtask
  task automatic test_nor_good;
    run_sweep(3, 3, 1'b0, 0, "nor_good");
  endtask
  task automatic test_nor_stuck;
    run_sweep(3, 3, 1'b1, 0, "nor_stuck0");
  endtask
  task automatic test_xor_vs_xnor;
    run_sweep(4, 5, 1'b0, 0, "xor_vs_xnor");
  endtask
  task automatic test_restart_from_done;
    run_sweep(0, 0, 1'b0, 0, "and_from_done");
  endtask
  task automatic test_start_while_busy;
    run_sweep(7, 7, 1'b0, 1, "start_busy");
    run_sweep(6, 1, 1'b0, 0, "buf_vs_or");
  endtask
  task automatic test_rst_mid;
    int cyc;
    @(negedge clk);
    mode = 3'd2;
    dut_mode = 3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (vec !== 3'b101 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (vec !== 3'b101) begin
      failures++;
      $display("FAIL rst_mid reach: vec=%b required 101", vec);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("rst_mid");
    run_sweep(5, 5, 1'b0, 0, "after_rst");
  endtask
  initial begin
    test_reset();
    test_nor_good();
    test_nor_stuck();
    test_xor_vs_xnor();
    test_restart_from_done();
    test_start_while_busy();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
